// File: rtl/clk_interval_timebase.sv
// -----------------------------------------------------------------------------
// clk_interval_timebase
//
// Free-running timebase for one clock domain. A phase accumulator adds
// SUBSEC_RATE every clock and wraps at CLK_RATE. Each wrap produces one
// sub-second tick. Over any CLK_RATE clocks this yields exactly SUBSEC_RATE
// ticks, with no long-term drift, even when CLK_RATE is not a multiple of
// SUBSEC_RATE. Tick spacing alternates between floor and ceil of the ratio.
//
// Optional build macro: CLK_INTERVAL_PPS_ALIGN_EN
//   When defined, a rising edge on pps re-phases the timebase to a second
//   boundary. The sub-second position is rounded to the nearest second.
//   When undefined, pps is ignored.
//
// Parameters:
//   CLK_RATE       clk frequency in Hz (>= SUBSEC_RATE)
//   SUBSEC_RATE    sub-second ticks per second
//   COUNTER_WIDTH  width of the since-boot counters and their snapshots
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   latchStrobe          capture a coherent snapshot of the since-boot counters
//   pps                  pulse-per-second input (alignment build only)
//   subsecTick           one-clk pulse per sub-second interval
//   secTick              one-clk pulse per second rollover (always with subsecTick)
//   subsecondsSinceBoot  free-running sub-second count
//   secondsSinceBoot     free-running seconds count
//   subsecondOfSecond    position within the current second, 0..SUBSEC_RATE-1
//   latchedSubseconds    snapshot of subsecondsSinceBoot
//   latchedSeconds       snapshot of secondsSinceBoot
//   latchValid           one-clk pulse when the snapshot outputs were updated
// -----------------------------------------------------------------------------
module clk_interval_timebase #(
    parameter int CLK_RATE      = 100000000,
    parameter int SUBSEC_RATE   = 1000000,
    parameter int COUNTER_WIDTH = 32,
    // With SUBSEC_RATE == 1, the position counter still needs one bit.
    // In that case the bit is always zero.
    localparam int SOS_W = (SUBSEC_RATE > 1) ? $clog2(SUBSEC_RATE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     latchStrobe,
    input  logic                     pps,
    output logic                     subsecTick,
    output logic                     secTick,
    output logic [COUNTER_WIDTH-1:0] subsecondsSinceBoot,
    output logic [COUNTER_WIDTH-1:0] secondsSinceBoot,
    output logic [SOS_W-1:0]         subsecondOfSecond,
    output logic [COUNTER_WIDTH-1:0] latchedSubseconds,
    output logic [COUNTER_WIDTH-1:0] latchedSeconds,
    output logic                     latchValid
);

    // The accumulator always stays below CLK_RATE, so acc + SUBSEC_RATE
    // stays below CLK_RATE + SUBSEC_RATE. The sum below carries one spare
    // bit so the compare never has to reason about wrap.
    localparam int ACC_W = (CLK_RATE + SUBSEC_RATE > 1) ?
                           $clog2(CLK_RATE + SUBSEC_RATE) : 1;

    localparam logic [ACC_W:0]   RATE_STEP = (ACC_W+1)'(SUBSEC_RATE);
    localparam logic [ACC_W:0]   CLK_LIM   = (ACC_W+1)'(CLK_RATE);
    localparam logic [SOS_W-1:0] SOS_LAST  = SOS_W'(SUBSEC_RATE - 1);
    localparam logic [SOS_W:0]   SOS_HALF  = (SOS_W+1)'(SUBSEC_RATE / 2);

    generate
        if (SUBSEC_RATE < 1 || SUBSEC_RATE > CLK_RATE) begin : gBadCfg
            $error("clk_interval_timebase: need 1 <= SUBSEC_RATE <= CLK_RATE");
        end
    endgenerate

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   accNext;
    logic             natTick;    // phase accumulator wrapped this edge
    logic             ppsAlign;   // pps rise re-phases the timebase this edge
    logic             anyTick;    // a sub-second tick happens this edge
    logic             secStep;    // seconds counter advances this edge
    logic             sosAtLast;
    logic             sosPastHalf;
    logic [SOS_W-1:0] sosNext;

`ifdef CLK_INTERVAL_PPS_ALIGN_EN
    // The registered copy of pps is not reset. A pps held high across
    // reset therefore does not look like a fresh rise on release.
    logic ppsQ;

    always_ff @(posedge clk) begin
        ppsQ <= pps;
    end

    assign ppsAlign = pps & ~ppsQ;
`else
    logic unusedPps;

    assign unusedPps = pps;
    assign ppsAlign  = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        sum         = {1'b0, acc} + RATE_STEP;
        natTick     = (sum >= CLK_LIM);
        accNext     = natTick ? (sum - CLK_LIM) : sum;

        sosAtLast   = (subsecondOfSecond == SOS_LAST);
        sosPastHalf = ({1'b0, subsecondOfSecond} >= SOS_HALF);

        anyTick     = natTick | ppsAlign;

        // Alignment wins over a natural tick on the same edge. It counts as
        // a single tick, and it bumps the seconds count only when we were
        // already in the second half of the current second.
        if (ppsAlign) begin
            secStep = sosPastHalf;
            sosNext = '0;
        end else if (natTick) begin
            secStep = sosAtLast;
            sosNext = sosAtLast ? '0 : subsecondOfSecond + SOS_W'(1);
        end else begin
            secStep = 1'b0;
            sosNext = subsecondOfSecond;
        end
    end

    // Timebase registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc                 <= '0;
            subsecTick          <= 1'b0;
            secTick             <= 1'b0;
            subsecondsSinceBoot <= '0;
            secondsSinceBoot    <= '0;
            subsecondOfSecond   <= '0;
        end else begin
            acc                 <= ppsAlign ? '0 : accNext[ACC_W-1:0];
            subsecTick          <= anyTick;
            secTick             <= secStep;
            subsecondOfSecond   <= sosNext;
            if (anyTick) begin
                subsecondsSinceBoot <= subsecondsSinceBoot + COUNTER_WIDTH'(1);
            end
            if (secStep) begin
                secondsSinceBoot <= secondsSinceBoot + COUNTER_WIDTH'(1);
            end
        end
    end

    // Snapshot registers. The snapshot samples the counter registers as they
    // stand before this edge. A tick on the strobe edge therefore shows up
    // in the live counters but not in the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            latchedSubseconds <= '0;
            latchedSeconds    <= '0;
            latchValid        <= 1'b0;
        end else begin
            latchValid <= latchStrobe;
            if (latchStrobe) begin
                latchedSubseconds <= subsecondsSinceBoot;
                latchedSeconds    <= secondsSinceBoot;
            end
        end
    end

endmodule
